core_col_sched: RTL and testbench

Parametrised layer sequencer for the diff NN core, replacing the fixed-width core top control. It accepts one layer job from the host over the core ready/valid/finish handshake, then dispatches row passes to a configurable set of PE columns. For each row it collects per-column completion and swaps the feature-map and guard ping-pong buffers. It sits between the host interface and the PE matrix and buffer banks, and adds column masking, multi-pass sequencing and abort.

---
 rtl/core_col_sched.sv | 219 +++++++++++++++++++++
 tb/tb_core_col_sched.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/core_col_sched.sv
// core_col_sched
//
// Layer sequencer for the diff NN core. It accepts one layer job from the
// host over a ready/valid handshake and then walks rows and passes. For each
// row it requests a start from every enabled PE column, collects each
// column's row-done pulse, and then swaps the feature-map and guard
// ping-pong banks of the enabled columns. core_finish pulses once when the
// last row of the last pass completes. An abort returns the sequencer to
// IDLE and clears all progress.
//
// Ports
//   clk, rst            core clock, asynchronous active-high reset
//   core_valid/ready    host job handshake (ready high only in IDLE)
//   core_finish         one-cycle pulse on normal layer completion
//   abort               synchronous abort of the running job
//   cfg_*               job configuration, sampled at accept
//   PE_col_ctrl_*       per-column row start (valid/ready) and row-done pulse
//   bit_mode, kernal_mode, is_odd_row, end_of_row,
//   fm_ping_pong, gd_ping_pong
//                       per-column attributes, forced to 0 on disabled columns
//   row_idx, pass_idx   current row and pass
//   busy                high whenever a job is in progress
module core_col_sched #(
  parameter int NUM_COL = 8,
  parameter int ROW_W   = 8,
  parameter int PASS_W  = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               core_valid,
  output logic               core_ready,
  output logic               core_finish,
  input  logic               abort,
  input  logic [ROW_W-1:0]   cfg_rows,
  input  logic [PASS_W-1:0]  cfg_passes,
  input  logic [NUM_COL-1:0] cfg_col_mask,
  input  logic               cfg_bit_mode,
  input  logic               cfg_kernal_mode,
  output logic [NUM_COL-1:0] PE_col_ctrl_valid,
  input  logic [NUM_COL-1:0] PE_col_ctrl_ready,
  input  logic [NUM_COL-1:0] PE_col_ctrl_finish,
  output logic [NUM_COL-1:0] bit_mode,
  output logic [NUM_COL-1:0] kernal_mode,
  output logic [NUM_COL-1:0] is_odd_row,
  output logic [NUM_COL-1:0] end_of_row,
  output logic [NUM_COL-1:0] fm_ping_pong,
  output logic [NUM_COL-1:0] gd_ping_pong,
  output logic [ROW_W-1:0]   row_idx,
  output logic [PASS_W-1:0]  pass_idx,
  output logic               busy
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_NEXT,
    S_DONE
  } state_t;

  state_t state_reg, state_next;

  logic [ROW_W-1:0]   rows_reg, rows_next;
  logic [PASS_W-1:0]  passes_reg, passes_next;
  logic [NUM_COL-1:0] mask_reg, mask_next;
  logic               bit_mode_reg, bit_mode_next;
  logic               kernal_mode_reg, kernal_mode_next;
  logic [ROW_W-1:0]   row_reg, row_next;
  logic [PASS_W-1:0]  pass_reg, pass_next;
  logic [NUM_COL-1:0] issued_reg, issued_next;
  logic [NUM_COL-1:0] done_reg, done_next;
  // The feature-map and guard banks always swap together, so one register
  // holds the bank select for both.
  logic [NUM_COL-1:0] pp_reg, pp_next;

  logic               issue_st;
  logic               last_row;
  logic               last_pass;
  logic [NUM_COL-1:0] fire;
  logic [NUM_COL-1:0] done_set;

  assign issue_st  = (state_reg == S_ISSUE);
  // Configs of zero never reach the counters, so cfg-1 cannot wrap here.
  assign last_row  = (row_reg == rows_reg - ROW_W'(1));
  assign last_pass = (pass_reg == passes_reg - PASS_W'(1));
  assign fire      = PE_col_ctrl_valid & PE_col_ctrl_ready;
  // A row-done pulse only counts for an enabled column that already took its
  // start request; anything else is treated as noise.
  assign done_set  = PE_col_ctrl_finish & issued_reg & mask_reg;

  assign core_ready  = (state_reg == S_IDLE);
  assign busy        = (state_reg != S_IDLE);
  assign core_finish = (state_reg == S_DONE);
  assign row_idx     = row_reg;
  assign pass_idx    = pass_reg;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_COL; gi++) begin : g_col
      // Valid stays up until this column's own handshake.
      assign PE_col_ctrl_valid[gi] = issue_st & mask_reg[gi] & ~issued_reg[gi];
      assign bit_mode[gi]          = mask_reg[gi] & bit_mode_reg;
      assign kernal_mode[gi]       = mask_reg[gi] & kernal_mode_reg;
      assign is_odd_row[gi]        = mask_reg[gi] & row_reg[0];
      assign end_of_row[gi]        = mask_reg[gi] & last_row;
      assign fm_ping_pong[gi]      = mask_reg[gi] & pp_reg[gi];
      assign gd_ping_pong[gi]      = mask_reg[gi] & pp_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= S_IDLE;
      rows_reg        <= '0;
      passes_reg      <= '0;
      mask_reg        <= '0;
      bit_mode_reg    <= 1'b0;
      kernal_mode_reg <= 1'b0;
      row_reg         <= '0;
      pass_reg        <= '0;
      issued_reg      <= '0;
      done_reg        <= '0;
      pp_reg          <= '0;
    end else begin
      state_reg       <= state_next;
      rows_reg        <= rows_next;
      passes_reg      <= passes_next;
      mask_reg        <= mask_next;
      bit_mode_reg    <= bit_mode_next;
      kernal_mode_reg <= kernal_mode_next;
      row_reg         <= row_next;
      pass_reg        <= pass_next;
      issued_reg      <= issued_next;
      done_reg        <= done_next;
      pp_reg          <= pp_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    rows_next        = rows_reg;
    passes_next      = passes_reg;
    mask_next        = mask_reg;
    bit_mode_next    = bit_mode_reg;
    kernal_mode_next = kernal_mode_reg;
    row_next         = row_reg;
    pass_next        = pass_reg;
    issued_next      = issued_reg;
    done_next        = done_reg;
    pp_next          = pp_reg;

    case (state_reg)
      S_IDLE: begin
        // An abort in the same cycle as a request blocks the accept.
        if (core_valid && !abort) begin
          rows_next        = cfg_rows;
          passes_next      = cfg_passes;
          mask_next        = cfg_col_mask;
          bit_mode_next    = cfg_bit_mode;
          kernal_mode_next = cfg_kernal_mode;
          row_next         = '0;
          pass_next        = '0;
          issued_next      = '0;
          done_next        = '0;
          pp_next          = '0;
          if ((cfg_rows == '0) || (cfg_passes == '0) || (cfg_col_mask == '0))
            state_next = S_DONE;
          else
            state_next = S_ISSUE;
        end
      end
      S_ISSUE: begin
        issued_next = issued_reg | fire;
        done_next   = done_reg | done_set;
        // Handshakes of this cycle count, so no extra ISSUE cycle is spent.
        if ((issued_next & mask_reg) == mask_reg)
          state_next = S_WAIT;
      end
      S_WAIT: begin
        done_next = done_reg | done_set;
        // Finishes of this cycle count, giving the 3-cycle row minimum.
        if ((done_next & mask_reg) == mask_reg)
          state_next = S_NEXT;
      end
      S_NEXT: begin
        pp_next     = pp_reg ^ mask_reg;
        issued_next = '0;
        done_next   = '0;
        if (!last_row) begin
          row_next   = row_reg + ROW_W'(1);
          state_next = S_ISSUE;
        end else if (!last_pass) begin
          row_next   = '0;
          pass_next  = pass_reg + PASS_W'(1);
          state_next = S_ISSUE;
        end else begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase

    // Abort discards all progress; the latched config is kept.
    if (abort && (state_reg != S_IDLE)) begin
      state_next  = S_IDLE;
      row_next    = '0;
      pass_next   = '0;
      issued_next = '0;
      done_next   = '0;
      pp_next     = '0;
    end
  end

endmodule

// File: tb/tb_core_col_sched.sv
module tb_core_col_sched;
  localparam int NC = 8;
  localparam int RW = 8;
  localparam int PW = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          core_valid;
  logic          core_ready;
  logic          core_finish;
  logic          abort;
  logic [RW-1:0] cfg_rows;
  logic [PW-1:0] cfg_passes;
  logic [NC-1:0] cfg_col_mask;
  logic          cfg_bit_mode;
  logic          cfg_kernal_mode;
  logic [NC-1:0] col_valid;
  logic [NC-1:0] pe_ready;
  logic [NC-1:0] fin_drv;
  logic [NC-1:0] bit_mode, kernal_mode, is_odd_row, end_of_row;
  logic [NC-1:0] fm_ping_pong, gd_ping_pong;
  logic [RW-1:0] row_idx;
  logic [PW-1:0] pass_idx;
  logic          busy;

  always #5 clk = ~clk;

  // PE column model: row-done pulse `delay` cycles after each handshake,
  // plus an injectable spurious finish vector.
  logic [NC-1:0] fin_model;
  logic [NC-1:0] spur;
  int            cnt [NC];
  int            delay;
  assign fin_drv = fin_model | spur;

  core_col_sched #(.NUM_COL(NC), .ROW_W(RW), .PASS_W(PW)) dut (
    .clk(clk), .rst(rst),
    .core_valid(core_valid), .core_ready(core_ready), .core_finish(core_finish),
    .abort(abort),
    .cfg_rows(cfg_rows), .cfg_passes(cfg_passes), .cfg_col_mask(cfg_col_mask),
    .cfg_bit_mode(cfg_bit_mode), .cfg_kernal_mode(cfg_kernal_mode),
    .PE_col_ctrl_valid(col_valid), .PE_col_ctrl_ready(pe_ready),
    .PE_col_ctrl_finish(fin_drv),
    .bit_mode(bit_mode), .kernal_mode(kernal_mode),
    .is_odd_row(is_odd_row), .end_of_row(end_of_row),
    .fm_ping_pong(fm_ping_pong), .gd_ping_pong(gd_ping_pong),
    .row_idx(row_idx), .pass_idx(pass_idx), .busy(busy)
  );

  typedef struct {
    logic [RW-1:0] row;
    logic [PW-1:0] pass;
    logic [NC-1:0] odd, eor, pp, valid, bm, km;
  } exp_t;

  exp_t          q[$];
  int            checks = 0;
  int            failures = 0;
  int            fin_count = 0;
  logic          prev_any = 1'b0;
  logic [NC-1:0] cur_mask = '0;

  // One clock cycle: record handshakes for the upcoming edge, advance to the
  // following falling edge, update the PE model and run the monitor.
  task automatic tick();
    logic [NC-1:0] hs;
    exp_t e;
    hs = col_valid & pe_ready;
    for (int i = 0; i < NC; i++) if (hs[i] === 1'b1) cnt[i] = delay;
    @(negedge clk);
    for (int i = 0; i < NC; i++) begin
      fin_model[i] = 1'b0;
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) fin_model[i] = 1'b1;
      end
    end
    if (busy === 1'b1) begin
      checks++;
      if (((col_valid | bit_mode | kernal_mode | is_odd_row | end_of_row |
            fm_ping_pong | gd_ping_pong) & ~cur_mask) !== '0) begin
        failures++;
        $display("FAIL masked_cols: valid=%h odd=%h eor=%h fm=%h bm=%h mask=%h required disabled bits 0",
                 col_valid, is_odd_row, end_of_row, fm_ping_pong, bit_mode, cur_mask);
      end
    end
    if ((|col_valid) && !prev_any) begin
      checks++;
      if (q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_dispatch: row=%0d pass=%0d valid=%h required no dispatch",
                 row_idx, pass_idx, col_valid);
      end else begin
        e = q.pop_front();
        if (row_idx !== e.row || pass_idx !== e.pass || is_odd_row !== e.odd ||
            end_of_row !== e.eor || fm_ping_pong !== e.pp || gd_ping_pong !== e.pp ||
            col_valid !== e.valid || bit_mode !== e.bm || kernal_mode !== e.km) begin
          failures++;
          $display("FAIL dispatch: got row=%0d pass=%0d odd=%h eor=%h fm=%h gd=%h valid=%h bm=%h km=%h required row=%0d pass=%0d odd=%h eor=%h pp=%h valid=%h bm=%h km=%h",
                   row_idx, pass_idx, is_odd_row, end_of_row, fm_ping_pong, gd_ping_pong,
                   col_valid, bit_mode, kernal_mode, e.row, e.pass, e.odd, e.eor, e.pp,
                   e.valid, e.bm, e.km);
        end
      end
    end
    prev_any = |col_valid;
    if (core_finish === 1'b1) fin_count++;
  endtask

  // Scoreboard: one expected record per row dispatch; returns final bank select.
  task automatic push_expect(input int rows, input int passes, input logic [NC-1:0] mask,
                             input logic bm, input logic km, output logic [NC-1:0] pp);
    exp_t e;
    pp = '0;
    for (int p = 0; p < passes; p++) begin
      for (int r = 0; r < rows; r++) begin
        e.row   = RW'(r);
        e.pass  = PW'(p);
        e.odd   = (r % 2 == 1) ? mask : '0;
        e.eor   = (r == rows - 1) ? mask : '0;
        e.pp    = pp;
        e.valid = mask;
        e.bm    = bm ? mask : '0;
        e.km    = km ? mask : '0;
        q.push_back(e);
        pp = pp ^ mask;
      end
    end
  endtask

  task automatic start_job(input int rows, input int passes, input logic [NC-1:0] mask,
                           input logic bm, input logic km);
    cur_mask        = mask;
    cfg_rows        = RW'(rows);
    cfg_passes      = PW'(passes);
    cfg_col_mask    = mask;
    cfg_bit_mode    = bm;
    cfg_kernal_mode = km;
    core_valid      = 1'b1;
    tick();
    checks++;
    if (busy !== 1'b1 || col_valid !== mask) begin
      failures++;
      $display("FAIL accept_t1: busy=%b valid=%h required busy=1 valid=%h", busy, col_valid, mask);
    end
    core_valid = 1'b0;
  endtask

  task automatic finish_job(input int fin_before, input logic [NC-1:0] final_pp);
    int n = 0;
    while (fin_count == fin_before && n < 300) begin
      tick();
      n++;
    end
    checks++;
    if (fin_count == fin_before) begin
      failures++;
      $display("FAIL finish_timeout: core_finish not seen in %0d cycles", n);
    end
    tick();
    checks++;
    if (core_ready !== 1'b1 || busy !== 1'b0 || fin_count !== fin_before + 1) begin
      failures++;
      $display("FAIL job_end: ready=%b busy=%b finishes=%0d required ready=1 busy=0 finishes=%0d",
               core_ready, busy, fin_count - fin_before, 1);
    end
    checks++;
    if (q.size() != 0 || fm_ping_pong !== final_pp || gd_ping_pong !== final_pp) begin
      failures++;
      $display("FAIL job_state: pending=%0d fm=%h gd=%h required pending=0 pp=%h",
               q.size(), fm_ping_pong, gd_ping_pong, final_pp);
    end
  endtask

  task automatic run_job(input int rows, input int passes, input logic [NC-1:0] mask,
                         input logic bm, input logic km, input int dly);
    logic [NC-1:0] pp;
    int fb;
    delay = dly;
    push_expect(rows, passes, mask, bm, km, pp);
    fb = fin_count;
    start_job(rows, passes, mask, bm, km);
    finish_job(fb, pp);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (core_ready !== 1'b1 || busy !== 1'b0 || core_finish !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: ready=%b busy=%b finish=%b required 1 0 0", core_ready, busy, core_finish);
    end
    checks++;
    if ((col_valid | bit_mode | kernal_mode | is_odd_row | end_of_row |
         fm_ping_pong | gd_ping_pong) !== '0 || row_idx !== '0 || pass_idx !== '0) begin
      failures++;
      $display("FAIL reset_outputs: valid=%h fm=%h gd=%h eor=%h row=%0d pass=%0d required all 0",
               col_valid, fm_ping_pong, gd_ping_pong, end_of_row, row_idx, pass_idx);
    end
  endtask

  task automatic test_basic();
    run_job(2, 1, 8'hFF, 1'b1, 1'b0, 3);
  endtask

  task automatic test_staggered();
    logic [NC-1:0] pp;
    int fb;
    delay = 3;
    push_expect(1, 1, 8'hFF, 1'b0, 1'b0, pp);
    fb = fin_count;
    pe_ready = 8'hF7;
    start_job(1, 1, 8'hFF, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      // A finish from column 3 before its handshake must be ignored.
      spur = (i == 1) ? 8'h08 : 8'h00;
      tick();
      checks++;
      if (col_valid !== 8'h08) begin
        failures++;
        $display("FAIL stagger_hold: cycle=%0d valid=%h required 08", i, col_valid);
      end
    end
    spur = '0;
    pe_ready = 8'hFF;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checks++;
      if (core_finish !== (k == 5) || (k < 5 && (busy !== 1'b1 || col_valid !== '0))) begin
        failures++;
        $display("FAIL stagger_wait: cycle=%0d finish=%b busy=%b valid=%h required finish=%b busy=1 valid=00",
                 k, core_finish, busy, col_valid, (k == 5));
      end
    end
    tick();
    checks++;
    if (core_ready !== 1'b1 || fin_count !== fb + 1 || q.size() != 0 || fm_ping_pong !== pp) begin
      failures++;
      $display("FAIL stagger_end: ready=%b finishes=%0d pending=%0d fm=%h required 1 1 0 %h",
               core_ready, fin_count - fb, q.size(), fm_ping_pong, pp);
    end
  endtask

  task automatic test_mask();
    logic [NC-1:0] pp;
    int fb;
    delay = 3;
    push_expect(2, 1, 8'h05, 1'b1, 1'b1, pp);
    fb = fin_count;
    start_job(2, 1, 8'h05, 1'b1, 1'b1);
    spur = 8'h02;
    finish_job(fb, pp);
    spur = '0;
  endtask

  task automatic test_degenerate();
    int fb;
    fb = fin_count;
    cur_mask        = 8'hFF;
    cfg_rows        = '0;
    cfg_passes      = PW'(1);
    cfg_col_mask    = 8'hFF;
    core_valid      = 1'b1;
    tick();
    core_valid = 1'b0;
    checks++;
    if (core_finish !== 1'b1 || core_ready !== 1'b0 || col_valid !== '0) begin
      failures++;
      $display("FAIL degenerate_t1: finish=%b ready=%b valid=%h required 1 0 00", core_finish, core_ready, col_valid);
    end
    tick();
    checks++;
    if (core_finish !== 1'b0 || core_ready !== 1'b1 || fin_count !== fb + 1) begin
      failures++;
      $display("FAIL degenerate_t2: finish=%b ready=%b finishes=%0d required 0 1 1",
               core_finish, core_ready, fin_count - fb);
    end
  endtask

  task automatic test_multipass();
    run_job(3, 2, 8'hFF, 1'b0, 1'b1, 1);
  endtask

  task automatic test_abort();
    logic [NC-1:0] pp;
    int fb;
    int n = 0;
    delay = 6;
    push_expect(2, 1, 8'hFF, 1'b0, 1'b0, pp);
    fb = fin_count;
    start_job(2, 2, 8'hFF, 1'b0, 1'b0);
    while (q.size() != 0 && n < 100) begin
      tick();
      n++;
    end
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL abort_setup: pending=%0d required 0", q.size());
    end
    repeat (2) tick();
    checks++;
    if (busy !== 1'b1 || col_valid !== '0 || fm_ping_pong !== 8'hFF) begin
      failures++;
      $display("FAIL abort_wait: busy=%b valid=%h fm=%h required 1 00 ff", busy, col_valid, fm_ping_pong);
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    checks++;
    if (core_ready !== 1'b1 || busy !== 1'b0 || col_valid !== '0 || fm_ping_pong !== '0 ||
        gd_ping_pong !== '0 || row_idx !== '0 || pass_idx !== '0) begin
      failures++;
      $display("FAIL abort_idle: ready=%b busy=%b valid=%h fm=%h gd=%h row=%0d pass=%0d required 1 0 00 00 00 0 0",
               core_ready, busy, col_valid, fm_ping_pong, gd_ping_pong, row_idx, pass_idx);
    end
    repeat (10) tick();
    checks++;
    if (fin_count !== fb || busy !== 1'b0) begin
      failures++;
      $display("FAIL abort_no_finish: finishes=%0d busy=%b required 0 0", fin_count - fb, busy);
    end
    run_job(1, 1, 8'hFF, 1'b0, 1'b0, 1);
  endtask

  initial begin
    rst             = 1'b1;
    core_valid      = 1'b0;
    abort           = 1'b0;
    cfg_rows        = '0;
    cfg_passes      = '0;
    cfg_col_mask    = '0;
    cfg_bit_mode    = 1'b0;
    cfg_kernal_mode = 1'b0;
    pe_ready        = 8'hFF;
    spur            = '0;
    fin_model       = '0;
    delay           = 1;
    for (int i = 0; i < NC; i++) cnt[i] = 0;

    test_reset();
    test_basic();
    test_staggered();
    test_mask();
    test_degenerate();
    test_multipass();
    test_abort();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
